// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues 1-cycle-latency instruction memory reads,
// buffers {pc, inst} in a small FIFO for decode, and flushes wrong-path work on a taken branch.
module fetch_unit #(
  parameter int ADDR     = 32,
  parameter int W_INST   = 32,
  parameter int DEPTH    = 4,
  parameter int PC_STEP  = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_i,
  input  logic [ADDR-1:0]   branch_addr_i,
  output logic              imem_req_o,
  output logic [ADDR-1:0]   imem_addr_o,
  input  logic [W_INST-1:0] imem_inst_i,
  output logic              v_o,
  output logic [W_INST-1:0] inst_o,
  output logic [ADDR-1:0]   pc_o,
  input  logic              ready_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR-1:0]   pc;
  logic [ADDR-1:0]   inflight_pc;
  logic              inflight;
  logic [CW-1:0]     count;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [W_INST-1:0] inst_mem [DEPTH];
  logic [ADDR-1:0]   pc_mem   [DEPTH];

  logic              push;
  logic              pop;
  logic [CW-1:0]     credit;

  // Handshake: decode takes the head on a cycle where v_o && ready_i are both high;
  // memory accepts every cycle imem_req_o is high and answers on imem_inst_i one cycle later.
  // Credits count queued plus in-flight entries so every response has a guaranteed slot.
  always_comb begin
    credit     = count + CW'(inflight);
    imem_req_o = !rst && !branch_i && (credit < CW'(DEPTH));
    push       = inflight && !branch_i;
    pop        = v_o && ready_i && !branch_i;
  end

  assign v_o         = (count != '0);
  assign imem_addr_o = pc;
  assign inst_o      = inst_mem[rd_ptr];
  assign pc_o        = pc_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= ADDR'(RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (branch_i) begin
      // Flush wins over any pop and over the response arriving this cycle.
      pc       <= branch_addr_i;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (imem_req_o) begin
        pc          <= pc + ADDR'(PC_STEP);
        inflight    <= 1'b1;
        inflight_pc <= pc;
      end else begin
        inflight <= 1'b0;
      end

      if (push) begin
        inst_mem[wr_ptr] <= imem_inst_i;
        pc_mem[wr_ptr]   <= inflight_pc;
        wr_ptr           <= wr_ptr + PW'(1);
      end

      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized ready/branch traffic, checked
// cycle by cycle against a transaction-level model of the fetch queue.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_inst_i = '0;
  logic        v_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        ready_i = 1'b0;

  fetch_unit #(
    .ADDR(32), .W_INST(32), .DEPTH(4), .PC_STEP(4), .RESET_PC(0)
  ) dut (
    .clk(clk), .rst(rst), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_inst_i(imem_inst_i),
    .v_o(v_o), .inst_o(inst_o), .pc_o(pc_o), .ready_i(ready_i)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // reference model state
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic        m_infl;
  logic [31:0] m_infl_pc;
  logic        mem_req;
  logic [31:0] mem_addr;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc      = 32'h0;
    m_infl    = 1'b0;
    m_infl_pc = '0;
    mem_req   = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs against model, advance model, respond as memory.
  task automatic tick(input logic br, input logic [31:0] ba, input logic rdy);
    logic exp_req;
    logic exp_v;
    branch_i      = br;
    branch_addr_i = ba;
    ready_i       = rdy;
    #1;
    exp_req = !br && ((exp_q.size() + int'(m_infl)) < 4);
    exp_v   = (exp_q.size() != 0);
    chk("imem_req", 32'(imem_req_o), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr_o, m_pc);
    chk("v_o", 32'(v_o), 32'(exp_v));
    if (exp_v) begin
      chk("pc_o", pc_o, exp_q[0]);
      chk("inst_o", inst_o, inst_of(exp_q[0]));
    end
    mem_req  = imem_req_o;
    mem_addr = imem_addr_o;

    if (br) begin
      exp_q.delete();
      m_pc   = ba;
      m_infl = 1'b0;
    end else begin
      if (exp_v && rdy) void'(exp_q.pop_front());
      if (m_infl) exp_q.push_back(m_infl_pc);
      if (exp_req) begin
        m_infl    = 1'b1;
        m_infl_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end else begin
        m_infl = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    imem_inst_i = mem_req ? inst_of(mem_addr) : $urandom();
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must fall without an edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_v_o", 32'(v_o), 32'h0);
    chk("rst_imem_req", 32'(imem_req_o), 32'h0);
    chk("rst_pc_o", pc_o, 32'h0);
    chk("rst_inst_o", inst_o, 32'h0);
    model_reset();
    branch_i = 1'b0;
    ready_i  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    // reset state
    @(negedge clk);
    #1;
    chk("reset_v_o", 32'(v_o), 32'h0);
    chk("reset_imem_req", 32'(imem_req_o), 32'h0);
    chk("reset_pc_o", pc_o, 32'h0);
    chk("reset_inst_o", inst_o, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // streaming with ready held high
    for (int i = 0; i < 10; i++) tick(1'b0, '0, 1'b1);

    // fill with ready low, then drain
    async_reset();
    for (int i = 0; i < 8; i++) tick(1'b0, '0, 1'b0);
    chk("full_count", 32'(exp_q.size()), 32'd4);
    for (int i = 0; i < 8; i++) tick(1'b0, '0, 1'b1);

    // branch with three queued and one in flight
    async_reset();
    for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b0);
    tick(1'b1, 32'h100, 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b0, '0, 1'b1);

    // back-to-back branches: last target wins
    tick(1'b1, 32'h200, 1'b1);
    tick(1'b1, 32'h300, 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b0, '0, 1'b1);

    // PC wrap at the top of the address space
    tick(1'b1, 32'hFFFF_FFFC, 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b0, '0, 1'b1);

    // randomized ready and branch traffic
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 15) == 0), $urandom() & 32'hFFFF_FFFC, ($urandom_range(0, 2) != 0));
    end

    // async reset mid-stream with three queued entries, then resume
    async_reset();
    for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b0);
    chk("pre_rst_queued", 32'(exp_q.size()), 32'd3);
    async_reset();
    for (int i = 0; i < 8; i++) tick(1'b0, '0, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
